timer_sched_ctrl: RTL and testbench
===================================

# timer_sched_ctrl

Controller for the management SoC's single 32-bit down-counting timer: it holds the software-visible configuration (load, reload, enable), sequences the counter through one-shot and periodic operation, and raises the zero-crossing event and interrupt. It sits between the CPU's CSR bus decode and the timer datapath, in the `core_clk` domain. Firmware uses it for delays and periodic ticks.

## Interface
- `WIDTH`, 32: counter and register width.
- `core_clk` in 1: sole clock.
- `core_rstn` in 1: reset, synchronous, active-low.
- `reg_we` in 1: register write strobe, one cycle.
- `reg_re` in 1: register read strobe, one cycle.
- `reg_addr` in 3: register index; map given under Operation.
- `reg_wdata` in WIDTH: write data.
- `reg_rdata` out WIDTH: read data, registered.
- `irq` out 1: level interrupt, `ev_pending & ev_enable`.
- `zero_pulse` out 1: one-cycle pulse on each zero event.
- `count` out WIDTH: live counter value, for debug.

## Operation
- Register map:
  - 0 LOAD (RW)
  - 1 RELOAD (RW)
  - 2 EN (RW, bit 0)
  - 3 UPDATE (WO; any write snapshots `count` into VALUE)
  - 4 VALUE (RO)
  - 5 EV_STATUS (RO; bit 0 = `count==0`)
  - 6 EV_PENDING (bit 0; read returns pending, writing 1 clears it)
  - 7 EV_ENABLE (RW, bit 0)
  - Unused bits read 0. Writes to RO addresses are ignored.
- FSM with states IDLE, RUN, HOLD:
  - IDLE (EN=0): `count <= LOAD` every cycle. Go to RUN when EN=1.
  - RUN: if `count>1`, decrement. If `count==1`, set `count<=0`, fire the zero event, then go to HOLD if RELOAD==0, else stay in RUN. If `count==0` and RELOAD!=0, set `count<=RELOAD` with no event. If `count==0` and RELOAD==0, go to HOLD.
  - HOLD: `count` stays 0 and no further events fire. A new cycle starts only by writing EN=0, then EN=1.
  - EN=0 from any state returns to IDLE on the next cycle.
- Zero event: sets EV_PENDING and pulses `zero_pulse`.
- Periodic period is RELOAD+1 cycles. The first expiry comes LOAD cycles after the EN=1 write takes effect.
- Enabling with LOAD=0 produces no event.
- LOAD writes while in RUN/HOLD have no effect until IDLE.
- RELOAD writes take effect at the next `count==0` reload.
- Arithmetic is unsigned WIDTH-bit. The counter never wraps below 0.

## Timing
- Reset values: LOAD=0, RELOAD=0, EN=0, VALUE=0, EV_PENDING=0, EV_ENABLE=0, state IDLE, `count=0`, `reg_rdata=0`, `irq=0`, `zero_pulse=0`.
- Register writes take effect on the edge where `reg_we`=1. State changes follow on the next edge.
- EN=1 written at edge N: RUN from N+1, first decrement at N+1.
- Read: `reg_rdata` is valid on the cycle after `reg_re`. It holds until the next read.
- `irq` and `zero_pulse` are asserted in the same cycle `count` becomes 0.
- EV_PENDING W1C in the same cycle as a new zero event: the set wins and pending stays 1.
- UPDATE write in the same cycle as a decrement: VALUE captures the pre-edge `count`.
- `core_rstn` low mid-count: all state returns to reset values on that edge, with no event.

## Structure
- Shared package `timer_pkg`:
  - register address constants (`TMR_LOAD`…`TMR_EV_ENABLE`)
  - FSM state enum (`TMR_IDLE`, `TMR_RUN`, `TMR_HOLD`)
- One natural sub-module, `timer_regs`: CSR decode, registers, W1C logic and read mux.
- The top level holds the FSM and the counter.

## Test plan
- One-shot: LOAD=5, RELOAD=0, EN=1.
  - `zero_pulse` fires exactly 5 cycles after the write.
  - State goes to HOLD with `count` at 0.
  - No second pulse within 100 cycles.
- Periodic: LOAD=3, RELOAD=9, EN=1.
  - Pulses at cycles 3, 13, 23, i.e. period 10.
  - EV_PENDING=1. With EV_ENABLE=1, `irq`=1.
  - Writing 1 to EV_PENDING clears `irq` on the next cycle.
- Snapshot: LOAD=32'hdcba9876, EN=1, wait 100 cycles, write UPDATE, read VALUE.
  - VALUE reads 32'hdcba9876−100 (±1 per the documented edge), and is below 32'hdcba9876.
- Collision: periodic RELOAD=4, W1C EV_PENDING issued on the exact zero-event cycle -> EV_PENDING reads 1.
- Reconfiguration: while running, write LOAD=7 and RELOAD=2.
  - Next period becomes 3 cycles.
  - After EN=0 then EN=1, first expiry comes at 7 cycles.
- Reset mid-count: assert `core_rstn`=0 for 1 cycle while `count`=50.
  - All outputs return to 0.
  - No `zero_pulse`; EN reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the management-SoC down-counting timer:
// CSR address map and controller state encoding.
package timer_pkg;

  localparam logic [2:0] TMR_LOAD       = 3'd0;
  localparam logic [2:0] TMR_RELOAD     = 3'd1;
  localparam logic [2:0] TMR_EN         = 3'd2;
  localparam logic [2:0] TMR_UPDATE     = 3'd3;
  localparam logic [2:0] TMR_VALUE      = 3'd4;
  localparam logic [2:0] TMR_EV_STATUS  = 3'd5;
  localparam logic [2:0] TMR_EV_PENDING = 3'd6;
  localparam logic [2:0] TMR_EV_ENABLE  = 3'd7;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_HOLD = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/timer_regs.sv
// Timer CSR block: register file, VALUE snapshot, sticky event pending
// with write-1-to-clear, and the registered read mux.
module timer_regs
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             reg_we,
  input  logic             reg_re,
  input  logic [2:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  input  logic [WIDTH-1:0] count,
  input  logic             zero_ev,
  output logic [WIDTH-1:0] reg_rdata,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] reload,
  output logic             en,
  output logic             ev_enable,
  output logic             ev_pending
);

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] rd_mux;
  logic             pend_clr;

  assign pend_clr = reg_we && (reg_addr == TMR_EV_PENDING) && reg_wdata[0];

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      TMR_LOAD:       rd_mux = load;
      TMR_RELOAD:     rd_mux = reload;
      TMR_EN:         rd_mux[0] = en;
      TMR_VALUE:      rd_mux = value;
      TMR_EV_STATUS:  rd_mux[0] = (count == '0);
      TMR_EV_PENDING: rd_mux[0] = ev_pending;
      TMR_EV_ENABLE:  rd_mux[0] = ev_enable;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      load       <= '0;
      reload     <= '0;
      en         <= 1'b0;
      value      <= '0;
      ev_enable  <= 1'b0;
      ev_pending <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      if (reg_we) begin
        case (reg_addr)
          TMR_LOAD:      load      <= reg_wdata;
          TMR_RELOAD:    reload    <= reg_wdata;
          TMR_EN:        en        <= reg_wdata[0];
          TMR_UPDATE:    value     <= count;
          TMR_EV_ENABLE: ev_enable <= reg_wdata[0];
          default: ;
        endcase
      end
      // A zero event landing on the same edge as a clear must not be lost.
      if (zero_ev)       ev_pending <= 1'b1;
      else if (pend_clr) ev_pending <= 1'b0;
      if (reg_re) reg_rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/timer_sched_ctrl.sv
// Timer controller top: IDLE/RUN/HOLD sequencing of the 32-bit down
// counter, zero-event generation, and the interrupt level.
module timer_sched_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             core_clk,
  input  logic             core_rstn,
  input  logic             reg_we,
  input  logic             reg_re,
  input  logic [2:0]       reg_addr,
  input  logic [WIDTH-1:0] reg_wdata,
  output logic [WIDTH-1:0] reg_rdata,
  output logic             irq,
  output logic             zero_pulse,
  output logic [WIDTH-1:0] count
);

  tmr_state_e       state;
  logic [WIDTH-1:0] load, reload;
  logic             en, ev_enable, ev_pending;
  logic [WIDTH-1:0] run_src;
  logic             stepping, zero_ev;

  timer_regs #(.WIDTH(WIDTH)) u_regs (
    .core_clk   (core_clk),
    .core_rstn  (core_rstn),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .count      (count),
    .zero_ev    (zero_ev),
    .reg_rdata  (reg_rdata),
    .load       (load),
    .reload     (reload),
    .en         (en),
    .ev_enable  (ev_enable),
    .ev_pending (ev_pending)
  );

  // The enabling edge already counts, so IDLE steps straight from LOAD.
  assign run_src  = (state == TMR_IDLE) ? load : count;
  assign stepping = en && (state != TMR_HOLD);
  assign zero_ev  = stepping && (run_src == WIDTH'(1));
  assign irq      = ev_pending && ev_enable;

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state      <= TMR_IDLE;
      count      <= '0;
      zero_pulse <= 1'b0;
    end else begin
      zero_pulse <= zero_ev;
      if (!en) begin
        state <= TMR_IDLE;
        count <= load;
      end else begin
        case (state)
          TMR_IDLE, TMR_RUN: begin
            state <= TMR_RUN;
            if (run_src > WIDTH'(1)) begin
              count <= run_src - WIDTH'(1);
            end else if (run_src == WIDTH'(1)) begin
              count <= '0;
              if (reload == '0) state <= TMR_HOLD;
            end else if (reload != '0) begin
              count <= reload;
            end else begin
              count <= '0;
              state <= TMR_HOLD;
            end
          end
          TMR_HOLD: count <= '0;
          default:  state <= TMR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Self-checking bench for timer_sched_ctrl: directed scenarios plus random
// LOAD/RELOAD trials against a closed-form timeline model.
module tb_timer_sched_ctrl;
  import timer_pkg::*;

  logic        core_clk = 1'b0;
  logic        core_rstn;
  logic        reg_we, reg_re;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq, zero_pulse;
  logic [31:0] count;

  int total = 0;
  int bad   = 0;

  timer_sched_ctrl #(.WIDTH(32)) dut (
    .core_clk   (core_clk),
    .core_rstn  (core_rstn),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq        (irq),
    .zero_pulse (zero_pulse),
    .count      (count)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge core_clk);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge core_clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge core_clk);
    reg_re = 1'b1; reg_addr = a;
    @(posedge core_clk); #1;
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  // Timeline model: t edges after the counter starts from L. First expiry at
  // t=L, then every R+1 edges if R!=0; R==0 means one-shot and hold at 0.
  task automatic check_run(input int L, input int R, input int n, input bit pend0);
    bit pend;
    int ec, p;
    bit ev;
    pend = pend0;
    for (int t = 1; t <= n; t++) begin
      @(posedge core_clk); #1;
      if (t < L) ec = L - t;
      else if (R == 0) ec = 0;
      else begin
        p  = (t - L) % (R + 1);
        ec = (p == 0) ? 0 : R + 1 - p;
      end
      if (R == 0) ev = (L > 0) && (t == L);
      else        ev = (t >= L) && ((t - L) % (R + 1) == 0);
      pend = pend | ev;
      chk("count", count, ec);
      chk("zero_pulse", {31'b0, zero_pulse}, {31'b0, ev});
      chk("irq", {31'b0, irq}, {31'b0, pend});
    end
  endtask

  // Restart from IDLE with fresh LOAD/RELOAD and a cleared pending flag.
  task automatic trial(input int L, input int R, input int n);
    wr(TMR_EN, 32'd0);
    wr(TMR_LOAD, L);
    wr(TMR_RELOAD, R);
    wr(TMR_EV_PENDING, 32'd1);
    wr(TMR_EN, 32'd1);
    check_run(L, R, n, 1'b0);
  endtask

  logic [31:0] d;
  int rl, rr;

  initial begin
    core_rstn = 1'b0;
    reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_count", count, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_zero_pulse", {31'b0, zero_pulse}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    core_rstn = 1'b1;

    rd(TMR_LOAD, d);       chk("rst_load", d, 32'd0);
    rd(TMR_RELOAD, d);     chk("rst_reload", d, 32'd0);
    rd(TMR_EN, d);         chk("rst_en", d, 32'd0);
    rd(TMR_VALUE, d);      chk("rst_value", d, 32'd0);
    rd(TMR_EV_PENDING, d); chk("rst_pending", d, 32'd0);
    rd(TMR_EV_ENABLE, d);  chk("rst_ev_enable", d, 32'd0);
    rd(TMR_EV_STATUS, d);  chk("status_zero", d, 32'd1);

    // Single-bit registers read back only bit 0.
    wr(TMR_EV_ENABLE, 32'hffff_ffff);
    rd(TMR_EV_ENABLE, d);  chk("ev_enable_bits", d, 32'd1);
    wr(TMR_EN, 32'hffff_fffe);
    rd(TMR_EN, d);         chk("en_bit0_only", d, 32'd0);
    wr(TMR_VALUE, 32'h1234);
    rd(TMR_VALUE, d);      chk("value_ro", d, 32'd0);

    // One-shot, then a long quiet stretch.
    trial(5, 0, 110);
    rd(TMR_EV_STATUS, d);  chk("status_hold", d, 32'd1);

    // Periodic, interrupt and clear.
    trial(3, 9, 30);
    rd(TMR_EV_PENDING, d); chk("periodic_pending", d, 32'd1);
    chk("periodic_irq", {31'b0, irq}, 32'd1);
    wr(TMR_EV_PENDING, 32'd1);
    chk("w1c_irq", {31'b0, irq}, 32'd0);

    // Clear issued on the very edge the counter reaches zero.
    trial(10, 4, 8);
    check_run(2, 4, 1, 1'b0);
    wr(TMR_EV_PENDING, 32'd1);
    chk("collision_pulse", {31'b0, zero_pulse}, 32'd1);
    rd(TMR_EV_PENDING, d); chk("collision_pending", d, 32'd1);

    // Reconfigure mid-run: LOAD waits for IDLE, RELOAD applies at next reload.
    trial(4, 5, 12);
    wr(TMR_LOAD, 32'd7);
    wr(TMR_RELOAD, 32'd2);
    check_run(2, 2, 12, 1'b1);
    wr(TMR_EN, 32'd0);
    wr(TMR_EN, 32'd1);
    check_run(7, 2, 20, 1'b1);

    // Snapshot while counting a large value.
    wr(TMR_EN, 32'd0);
    wr(TMR_LOAD, 32'hdcba9876);
    wr(TMR_EN, 32'd1);
    repeat (99) @(posedge core_clk);
    wr(TMR_UPDATE, 32'd0);
    rd(TMR_VALUE, d);
    chk("snapshot_value", d, 32'hdcba9876 - 32'd99);
    chk("snapshot_below", {31'b0, d < 32'hdcba9876}, 32'd1);

    // Boundary and random trials.
    trial(0, 0, 20);
    trial(0, 3, 20);
    trial(1, 0, 10);
    trial(1, 1, 12);
    for (int i = 0; i < 8; i++) begin
      rl = $urandom_range(0, 20);
      rr = $urandom_range(0, 12);
      trial(rl, rr, 45);
    end

    // Reset in the middle of a count.
    trial(200, 0, 149);
    rd(TMR_LOAD, d);       chk("pre_rst_load", d, 32'd200);
    chk("pre_rst_count", count, 32'd50);
    @(negedge core_clk);
    core_rstn = 1'b0;
    @(posedge core_clk); #1;
    chk("midrst_count", count, 32'd0);
    chk("midrst_zero_pulse", {31'b0, zero_pulse}, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    chk("midrst_rdata", reg_rdata, 32'd0);
    core_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge core_clk); #1;
      chk("post_rst_count", count, 32'd0);
      chk("post_rst_pulse", {31'b0, zero_pulse}, 32'd0);
    end
    rd(TMR_EN, d);         chk("post_rst_en", d, 32'd0);
    rd(TMR_LOAD, d);       chk("post_rst_load", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
